pc_sequencer: RTL and testbench

- Fetch-side controller for the 32-bit MIPS core.
- Owns the word-addressed program counter: each PC step is +1, one 32-bit instruction per address.
- Sequences instruction-memory requests over a req/ack handshake that allows variable latency.
- Applies branch, jump and jump-register redirects from decode, honours the pipeline stall, and delivers each fetched instruction with its PC.

---
 rtl/pc_seq_pkg.sv | 36 +++
 rtl/pc_seq_target.sv | 28 ++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and redirect arithmetic for the fetch-side PC sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned JIDX_W = 26;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } pc_seq_state_e;

  // jr > j > br; with nothing asserted the fall-through base is returned.
  function automatic logic [PC_W-1:0] calc_redirect(
    input logic [PC_W-1:0]   base,
    input logic              br,
    input logic [PC_W-1:0]   off,
    input logic              j,
    input logic [JIDX_W-1:0] jidx,
    input logic              jr,
    input logic [PC_W-1:0]   jrt
  );
    logic [PC_W-1:0] target;
    if (jr) begin
      target = jrt;
    end else if (j) begin
      target = {base[PC_W-1:JIDX_W], jidx};
    end else if (br) begin
      target = base + off;
    end else begin
      target = base;
    end
    return target;
  endfunction

endpackage

// File: rtl/pc_seq_target.sv
// Combinational redirect detection and target calculation relative to instr_pc + 1.
module pc_seq_target
  import pc_seq_pkg::*;
#(
  parameter int unsigned OFFSET_W = 16
) (
  input  logic [PC_W-1:0]     instr_pc,
  input  logic                br_taken,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                j_valid,
  input  logic [JIDX_W-1:0]   j_target,
  input  logic                jr_valid,
  input  logic [PC_W-1:0]     jr_target,
  output logic                redirect,
  output logic [PC_W-1:0]     target
);

  logic [PC_W-1:0] base;
  logic [PC_W-1:0] off_ext;

  always_comb begin
    base     = instr_pc + 32'd1;
    off_ext  = {{(PC_W - OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};
    redirect = br_taken | j_valid | jr_valid;
    target   = calc_redirect(base, br_taken, off_ext, j_valid, j_target, jr_valid, jr_target);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: req/ack instruction fetch with branch/jump/jr redirects and stall.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned OFFSET_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic                j_valid,
  input  logic [JIDX_W-1:0]   j_target,
  input  logic                jr_valid,
  input  logic [PC_W-1:0]     jr_target,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr,
  output logic [PC_W-1:0]     instr_pc,
  output logic                instr_valid,
  output logic [PC_W-1:0]     pc
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]         perf_fetch,
  output logic [31:0]         perf_wait
`endif
);

  pc_seq_state_e   state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] instr_pc_q;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            valid_q;
  logic            redirect;
  logic [PC_W-1:0] target;
  logic            deliver;

  pc_seq_target #(
    .OFFSET_W (OFFSET_W)
  ) u_target (
    .instr_pc  (instr_pc_q),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .j_valid   (j_valid),
    .j_target  (j_target),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .redirect  (redirect),
    .target    (target)
  );

  assign deliver = (state_q == FETCH) && imem_ack && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q <= stall ? HOLD : FETCH;
          req_q   <= !stall;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pc_q <= target;
            end else begin
              valid_q    <= 1'b1;
              instr_q    <= imem_rdata;
              instr_pc_q <= pc_q;
              pc_q       <= pc_q + 32'd1;
            end
            state_q <= stall ? HOLD : FETCH;
            req_q   <= !stall;
          end else if (redirect) begin
            // Address changes under an open request: drop req for a cycle to cancel it.
            pc_q    <= target;
            state_q <= HOLD;
            req_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q <= target;
          end
          if (!stall) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (deliver && (perf_fetch_q != 32'hFFFF_FFFF)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (req_q && !imem_ack && (perf_wait_q != 32'hFFFF_FFFF)) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_wait  = perf_wait_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with an all-ones reset vector covers PC wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        j_valid;
  logic [25:0] j_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        imem_ack;

  logic        imem_req,   w_imem_req;
  logic [31:0] imem_addr,  w_imem_addr;
  logic [31:0] imem_rdata, w_imem_rdata;
  logic [31:0] instr,      w_instr;
  logic [31:0] instr_pc,   w_instr_pc;
  logic        instr_valid, w_instr_valid;
  logic [31:0] pc,         w_pc;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] perf_fetch, perf_wait, w_perf_fetch, w_perf_wait;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign w_imem_rdata = mem_word(w_imem_addr);

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .OFFSET_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .j_valid     (j_valid),
    .j_target    (j_target),
    .jr_valid    (jr_valid),
    .jr_target   (jr_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc          (pc)
`ifdef PC_SEQ_PERF_EN
    ,
    .perf_fetch  (perf_fetch),
    .perf_wait   (perf_wait)
`endif
  );

  pc_sequencer #(
    .RESET_VECTOR (32'hFFFF_FFFF),
    .OFFSET_W     (16)
  ) dut_w (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .j_valid     (j_valid),
    .j_target    (j_target),
    .jr_valid    (jr_valid),
    .jr_target   (jr_target),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (w_imem_rdata),
    .instr       (w_instr),
    .instr_pc    (w_instr_pc),
    .instr_valid (w_instr_valid),
    .pc          (w_pc)
`ifdef PC_SEQ_PERF_EN
    ,
    .perf_fetch  (w_perf_fetch),
    .perf_wait   (w_perf_wait)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ack = 1'b1;
    br_taken = 1'b0; br_offset = '0; j_valid = 1'b0; j_target = '0;
    jr_valid = 1'b0; jr_target = '0;

    // Reset held for three edges
    tick(); tick(); tick();
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ipc",   instr_pc, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_pc_w",  w_pc, 32'hFFFF_FFFF);
    rst = 1'b0;

    // BOOT -> FETCH
    tick();
    check("boot_req",   {31'b0, imem_req}, 32'd1);
    check("boot_addr",  imem_addr, 32'd0);
    check("boot_valid", {31'b0, instr_valid}, 32'd0);

    // First delivery two edges after reset release, then one per cycle
    tick();
    check("seq0_valid", {31'b0, instr_valid}, 32'd1);
    check("seq0_ipc",   instr_pc, 32'd0);
    check("seq0_instr", instr, 32'hDEAD_0000);
    check("wrap0_ipc",  w_instr_pc, 32'hFFFF_FFFF);
    tick();
    check("seq1_ipc",   instr_pc, 32'd1);
    check("seq1_valid", {31'b0, instr_valid}, 32'd1);
    check("wrap1_ipc",  w_instr_pc, 32'd0);
    check("wrap1_inst", w_instr, 32'hDEAD_0000);
    tick();
    check("seq2_ipc", instr_pc, 32'd2);
    tick();
    check("seq3_ipc", instr_pc, 32'd3);
    for (int i = 4; i <= 10; i++) tick();
    check("seq10_ipc", instr_pc, 32'd10);
    check("seq10_pc",  pc, 32'd11);

    // Branch -4 from instr_pc 10: word 11 acked this cycle is dropped
    br_taken = 1'b1; br_offset = 16'hFFFC;
    tick();
    br_taken = 1'b0;
    check("br_drop_valid", {31'b0, instr_valid}, 32'd0);
    check("br_pc",         pc, 32'd7);
    tick();
    check("br_valid", {31'b0, instr_valid}, 32'd1);
    check("br_ipc",   instr_pc, 32'd7);

    // All three redirects together: jr wins
    jr_valid = 1'b1; jr_target = 32'h100; j_valid = 1'b1; j_target = 26'h3;
    br_taken = 1'b1; br_offset = 16'h0005;
    tick();
    jr_valid = 1'b0; j_valid = 1'b0; br_taken = 1'b0;
    check("prio_drop", {31'b0, instr_valid}, 32'd0);
    tick();
    check("prio_ipc",   instr_pc, 32'h100);
    check("prio_instr", instr, 32'hDEAD_0100);

    // Reach 0x0400_0010 via jr, then jump keeps base[31:26]
    jr_valid = 1'b1; jr_target = 32'h0400_0010;
    tick();
    jr_valid = 1'b0;
    tick();
    check("jr_ipc", instr_pc, 32'h0400_0010);
    j_valid = 1'b1; j_target = 26'h3;
    tick();
    j_valid = 1'b0;
    check("j_pc", pc, 32'h0400_0003);
    tick();
    check("j_ipc", instr_pc, 32'h0400_0003);

    // Waited memory (ack on the third request cycle) with stall raised mid-request
    imem_ack = 1'b0;
    tick();
    check("wait1_req",  {31'b0, imem_req}, 32'd1);
    check("wait1_addr", imem_addr, 32'h0400_0004);
    stall = 1'b1;
    tick();
    check("wait2_req",  {31'b0, imem_req}, 32'd1);
    check("wait2_addr", imem_addr, 32'h0400_0004);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    check("stall_ipc",   instr_pc, 32'h0400_0004);
    check("stall_req",   {31'b0, imem_req}, 32'd0);
    check("stall_pc",    pc, 32'h0400_0005);
    tick();
    check("hold1_req",   {31'b0, imem_req}, 32'd0);
    check("hold1_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("hold2_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    check("resume_req",  {31'b0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h0400_0005);

    // Redirect without ack cancels the request for one cycle
    br_taken = 1'b1; br_offset = 16'h0002;
    tick();
    br_taken = 1'b0;
    check("cancel_req", {31'b0, imem_req}, 32'd0);
    check("cancel_pc",  pc, 32'h0400_0007);
    tick();
    check("reissue_req",  {31'b0, imem_req}, 32'd1);
    check("reissue_addr", imem_addr, 32'h0400_0007);
`ifdef PC_SEQ_PERF_EN
    check("perf_fetch", perf_fetch, 32'd16);
    check("perf_wait",  perf_wait, 32'd3);
`endif

    // Reset during an unacked fetch; a late ack in BOOT is ignored
    rst = 1'b1;
    tick();
    check("rrst_req",   {31'b0, imem_req}, 32'd0);
    check("rrst_valid", {31'b0, instr_valid}, 32'd0);
    check("rrst_pc",    pc, 32'd0);
`ifdef PC_SEQ_PERF_EN
    check("rrst_pfetch", perf_fetch, 32'd0);
    check("rrst_pwait",  perf_wait, 32'd0);
`endif
    rst = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check("refetch_req",    {31'b0, imem_req}, 32'd1);
    check("refetch_addr",   imem_addr, 32'd0);
    tick();
    check("late_ack_valid2", {31'b0, instr_valid}, 32'd0);
    check("refetch_hold",    imem_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
